// File: rtl/ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid_stage
// Description : EX/MEM pipeline register with valid/ready handshake, a
//               two-entry skid buffer, synchronous flush, bubble control
//               masking and a forwarding tap.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid_stage #(
    parameter int DATAWIDTH = 32,
    parameter int REGINDEX  = 5,
    parameter int CTRLWIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] alu_in,
    input  logic [DATAWIDTH-1:0] pcm_in,
    input  logic [DATAWIDTH-1:0] datareg_in,
    input  logic [REGINDEX-1:0]  regd_in,
    input  logic [CTRLWIDTH-1:0] ctrl_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] alu_out,
    output logic [DATAWIDTH-1:0] pcm_out,
    output logic [DATAWIDTH-1:0] datareg_out,
    output logic [REGINDEX-1:0]  regd_out,
    output logic [CTRLWIDTH-1:0] ctrl_out,
    output logic                 fwd_en,
    output logic [1:0]           occupancy
);

    localparam int c_PW = 3 * DATAWIDTH + REGINDEX + CTRLWIDTH;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_skid;
    logic [c_PW-1:0] w_in_beat;
    logic            w_acc_in;
    logic            w_acc_out;
    logic            w_load_head_in;
    logic            w_load_head_skid;
    logic            w_load_skid;

    assign w_in_beat = {alu_in, pcm_in, datareg_in, regd_in, ctrl_in};

    // Ready comes only from registered state (and reset), never from out_ready.
    assign in_ready  = ~rst & (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign w_acc_in  = in_valid & in_ready;
    assign w_acc_out = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_acc_in) w_state_next = S_ONE;
                S_ONE: begin
                    if (w_acc_in && !w_acc_out)      w_state_next = S_FULL;
                    else if (!w_acc_in && w_acc_out) w_state_next = S_EMPTY;
                end
                S_FULL:  if (w_acc_out) w_state_next = S_ONE;
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_load_head_in = w_acc_in;
                S_ONE: begin
                    w_load_head_in = w_acc_in & w_acc_out;
                    w_load_skid    = w_acc_in & ~w_acc_out;
                end
                S_FULL:  w_load_head_skid = w_acc_out;
                default: ;
            endcase
        end
    end

    // Payload holds across flush so data outputs keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= w_in_beat;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_beat;
            end
        end
    end

    assign alu_out     = r_head[CTRLWIDTH + REGINDEX + 2 * DATAWIDTH +: DATAWIDTH];
    assign pcm_out     = r_head[CTRLWIDTH + REGINDEX + DATAWIDTH +: DATAWIDTH];
    assign datareg_out = r_head[CTRLWIDTH + REGINDEX +: DATAWIDTH];
    assign regd_out    = r_head[CTRLWIDTH +: REGINDEX];
    assign ctrl_out    = out_valid ? r_head[CTRLWIDTH-1:0] : '0;
    assign fwd_en      = out_valid & ctrl_out[0] & (regd_out != '0);
    assign occupancy   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_skid_stage
// Description : Self-checking bench for ex_mem_skid_stage: directed scenarios
//               plus randomized traffic against a bounded-FIFO reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pcm;
        logic [31:0] dr;
        logic [4:0]  regd;
        logic [8:0]  ctrl;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, fwd_en;
    logic [31:0] alu_in, pcm_in, datareg_in, alu_out, pcm_out, datareg_out;
    logic [4:0]  regd_in, regd_out;
    logic [8:0]  ctrl_in, ctrl_out;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    ex_mem_skid_stage #(.DATAWIDTH(32), .REGINDEX(5), .CTRLWIDTH(9)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_in(alu_in), .pcm_in(pcm_in), .datareg_in(datareg_in),
        .regd_in(regd_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .pcm_out(pcm_out), .datareg_out(datareg_out),
        .regd_out(regd_out), .ctrl_out(ctrl_out),
        .fwd_en(fwd_en), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [8:0] ctl);
        in_valid   = v;
        alu_in     = alu;
        pcm_in     = alu + 32'h1000;
        datareg_in = ~alu;
        regd_in    = rd;
        ctrl_in    = ctl;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'hDEAD, 5'd3, 9'h1FF);
        tick(); tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (ctrl_out !== 9'h0) begin fails++; $display("FAIL reset_ctrl: got %h want 0", ctrl_out); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        tests++; if (alu_out !== 32'h0) begin fails++; $display("FAIL reset_alu: got %h want 0", alu_out); end
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 9'h0);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 5'd7, 9'h101);
            tick();
            tests++; if (alu_out !== vals[i]) begin fails++; $display("FAIL stream_alu_%0d: got %h want %h", i, alu_out, vals[i]); end
            tests++; if (occupancy !== 2'd1) begin fails++; $display("FAIL stream_occ_%0d: got %0d want 1", i, occupancy); end
        end
        tests++; if (pcm_out !== 32'h1030 || datareg_out !== ~32'h30) begin
            fails++; $display("FAIL stream_fields: pcm %h dr %h want 1030 / %h", pcm_out, datareg_out, ~32'h30);
        end
        drive(1'b0, 32'h0, 5'd0, 9'h0);
        tick();
        tests++; if (occupancy !== 2'd0 || ctrl_out !== 9'h0) begin
            fails++; $display("FAIL stream_drain: occ %0d ctrl %h want 0/0", occupancy, ctrl_out);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd1, 9'h001); tick();
        drive(1'b1, 32'hB, 5'd2, 9'h001); tick();
        drive(1'b0, 32'h0, 5'd0, 9'h0);
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL skid_occ: got %0d want 2", occupancy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL skid_in_ready: got %b want 0", in_ready); end
        tests++; if (alu_out !== 32'hA) begin fails++; $display("FAIL skid_head: got %h want a", alu_out); end
        out_ready = 1'b1;
        tick();
        tests++; if (alu_out !== 32'hB) begin fails++; $display("FAIL skid_second: got %h want b", alu_out); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL skid_ready_after_pop: got %b want 1", in_ready); end
        tick();
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL skid_drain: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd1, 9'h1FF); tick();
        drive(1'b1, 32'hB, 5'd2, 9'h1FF); tick();
        drive(1'b1, 32'hC, 5'd3, 9'h1FF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 9'h0);
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        tests++; if (ctrl_out !== 9'h0) begin fails++; $display("FAIL flush_ctrl: got %h want 0", ctrl_out); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost_%0d: out_valid %b alu %h want no beat", i, out_valid, alu_out); end
        end
    endtask

    task automatic test_forwarding();
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 5'd5, 9'h001); tick();
        tests++; if (fwd_en !== 1'b1) begin fails++; $display("FAIL fwd_r5: got %b want 1", fwd_en); end
        drive(1'b1, 32'h66, 5'd0, 9'h001); tick();
        tests++; if (fwd_en !== 1'b0) begin fails++; $display("FAIL fwd_r0: got %b want 0", fwd_en); end
        drive(1'b1, 32'h77, 5'd5, 9'h1FE); tick();
        tests++; if (fwd_en !== 1'b0) begin fails++; $display("FAIL fwd_nowrite: got %b want 0", fwd_en); end
        drive(1'b0, 32'h0, 5'd0, 9'h0); tick();
        tests++; if (fwd_en !== 1'b0) begin fails++; $display("FAIL fwd_bubble: got %b want 0", fwd_en); end
    endtask

    // Reference: a FIFO of capacity two; accept when room and not in reset,
    // pop when MEM takes the front, flush/reset empty it.
    task automatic test_random();
        beat_t q[$];
        beat_t b;
        logic  exp_acc_in, exp_acc_out;
        int    pushed = 0;
        int    popped = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst       = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            b.alu  = $urandom; b.pcm = $urandom; b.dr = $urandom;
            b.regd = 5'($urandom); b.ctrl = 9'($urandom);
            in_valid   = ($urandom_range(0, 3) != 0);
            alu_in     = b.alu; pcm_in = b.pcm; datareg_in = b.dr;
            regd_in    = b.regd; ctrl_in = b.ctrl;
            #1;
            exp_acc_in  = in_valid && !rst && (q.size() < 2);
            exp_acc_out = (q.size() > 0) && out_ready;
            tests++; if (in_ready !== (!rst && q.size() < 2)) begin
                fails++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, in_ready, (!rst && q.size() < 2));
            end
            tick();
            if (rst || flush) begin
                q.delete();
            end else begin
                if (exp_acc_out) begin void'(q.pop_front()); popped++; end
                if (exp_acc_in)  begin q.push_back(b); pushed++; end
            end
            tests++; if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0)) begin
                fails++; $display("FAIL rnd_occ cyc %0d: occ %0d valid %b want %0d", cyc, occupancy, out_valid, q.size());
            end
            if (q.size() > 0) begin
                tests++; if ({alu_out, pcm_out, datareg_out, regd_out, ctrl_out} !== q[0]) begin
                    fails++; $display("FAIL rnd_head cyc %0d: got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h", cyc,
                        alu_out, pcm_out, datareg_out, regd_out, ctrl_out,
                        q[0].alu, q[0].pcm, q[0].dr, q[0].regd, q[0].ctrl);
                end
                tests++; if (fwd_en !== (q[0].ctrl[0] && q[0].regd != 5'd0)) begin
                    fails++; $display("FAIL rnd_fwd cyc %0d: got %b want %b", cyc, fwd_en, (q[0].ctrl[0] && q[0].regd != 5'd0));
                end
            end else begin
                tests++; if (ctrl_out !== 9'h0 || fwd_en !== 1'b0) begin
                    fails++; $display("FAIL rnd_bubble cyc %0d: ctrl %h fwd %b want 0/0", cyc, ctrl_out, fwd_en);
                end
            end
        end
        tests++; if (pushed == 0 || popped == 0) begin
            fails++; $display("FAIL rnd_activity: pushed %0d popped %0d want both nonzero", pushed, popped);
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 9'h0);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_forwarding();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
